// File: rtl/rng_pkg.sv
// Shared types and helpers for the random-number scheduler.
package rng_pkg;

   localparam int unsigned NIBBLE_W = 4;
   localparam int unsigned MAX_W    = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GATHER = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Smallest 2^k-1 covering limit-1; limit 0 selects the full range.
   function automatic logic [MAX_W-1:0] range_mask(input logic [MAX_W-1:0] lim);
      logic [MAX_W-1:0] v;
      if (lim == '0) begin
         v = '1;
      end else begin
         v = lim - MAX_W'(1);
         v = v | (v >> 1);
         v = v | (v >> 2);
         v = v | (v >> 4);
         v = v | (v >> 8);
         v = v | (v >> 16);
      end
      return v;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first set request at or above the pointer, with wrap.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   grant_c,
   output logic               valid_c
);

   always_comb begin
      int unsigned idx;
      grant_c = '0;
      valid_c = 1'b0;
      idx     = 0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         idx = (32'(ptr) + off) % NUM_REQ;
         if (!valid_c && req[IDX_W'(idx)]) begin
            valid_c = 1'b1;
            grant_c = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/rng_scheduler.sv
// Shares one 4-bit random source among requesters, building range-limited words
// with masking plus bounded rejection sampling.
module rng_scheduler
   import rng_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [NIBBLE_W-1:0]      rand_nibble,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*OUT_W-1:0] limit,
   output logic [NUM_REQ-1:0]       ack,
   output logic [OUT_W-1:0]         rand_out,
   output logic                     busy
);

   localparam int unsigned IDX_W   = $clog2(NUM_REQ);
   localparam int unsigned NIB_CNT = OUT_W / NIBBLE_W;
   localparam int unsigned CNT_W   = $clog2(NIB_CNT) + 1;
   localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [OUT_W-1:0]   limit_q, limit_d;
   logic [OUT_W-1:0]   mask_q, mask_d;
   logic [OUT_W-1:0]   shift_q, shift_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic [CNT_W-1:0]   gcnt_q, gcnt_d;
   logic [OUT_W-1:0]   rand_out_q, rand_out_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               busy_q, busy_d;

   logic [IDX_W-1:0]   grant_c;
   logic               valid_c;
   logic [OUT_W-1:0]   lim_sel_c;
   logic [OUT_W-1:0]   masked_c;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .grant_c (grant_c),
      .valid_c (valid_c)
   );

   // Limit slice belonging to the candidate requester.
   always_comb begin
      lim_sel_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_c == IDX_W'(i)) lim_sel_c = limit[i*OUT_W +: OUT_W];
      end
   end

   assign masked_c = shift_q & mask_q;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      limit_d    = limit_q;
      mask_d     = mask_q;
      shift_d    = shift_q;
      retry_d    = retry_q;
      gcnt_d     = gcnt_q;
      rand_out_d = rand_out_q;
      ack_d      = '0;
      case (state_q)
         IDLE: begin
            if (valid_c) begin
               grant_d = grant_c;
               limit_d = lim_sel_c;
               mask_d  = OUT_W'(range_mask(MAX_W'(lim_sel_c)));
               retry_d = '0;
               gcnt_d  = '0;
               state_d = GATHER;
            end
         end
         GATHER: begin
            // First nibble drifts down to the LSBs as later ones arrive.
            shift_d = {rand_nibble, shift_q[OUT_W-1:NIBBLE_W]};
            if (gcnt_q == CNT_W'(NIB_CNT - 1)) state_d = CHECK;
            else                               gcnt_d  = gcnt_q + CNT_W'(1);
         end
         CHECK: begin
            if (limit_q == '0 || masked_c < limit_q) begin
               rand_out_d = masked_c;
               ack_d      = NUM_REQ'(1) << grant_q;
               state_d    = DONE;
            end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
               retry_d = retry_q + RETRY_W'(1);
               gcnt_d  = '0;
               state_d = GATHER;
            end else begin
               // masked <= 2*limit-2, so one subtraction lands inside the range.
               rand_out_d = masked_c - limit_q;
               ack_d      = NUM_REQ'(1) << grant_q;
               state_d    = DONE;
            end
         end
         DONE: begin
            ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         grant_q    <= '0;
         limit_q    <= '0;
         mask_q     <= '0;
         shift_q    <= '0;
         retry_q    <= '0;
         gcnt_q     <= '0;
         rand_out_q <= '0;
         ack_q      <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         limit_q    <= limit_d;
         mask_q     <= mask_d;
         shift_q    <= shift_d;
         retry_q    <= retry_d;
         gcnt_q     <= gcnt_d;
         rand_out_q <= rand_out_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
      end
   end

   assign ack      = ack_q;
   assign rand_out = rand_out_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_rng_scheduler.sv
// Directed bench for rng_scheduler: arbitration order, latency, rejection and fallback.
module tb_rng_scheduler;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned OUT_W   = 16;

   logic                     Clk;
   logic                     Reset;
   logic [3:0]               rand_nibble;
   logic [NUM_REQ-1:0]       req;
   logic [NUM_REQ*OUT_W-1:0] limit;
   logic [NUM_REQ-1:0]       ack;
   logic [OUT_W-1:0]         rand_out;
   logic                     busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   rng_scheduler #(.NUM_REQ(NUM_REQ), .OUT_W(OUT_W), .MAX_RETRY(3)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .rand_nibble (rand_nibble),
      .req         (req),
      .limit       (limit),
      .ack         (ack),
      .rand_out    (rand_out),
      .busy        (busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic do_reset();
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
   endtask

   // Drives one transaction from its accept edge (edge 1) until ack; nibs[k] feeds edge k+2.
   task automatic run_txn(input logic [3:0] nibs [$], input logic [3:0] fill,
                          output int edges, output logic [3:0] ack_seen,
                          output logic [15:0] out_seen);
      edges    = -1;
      ack_seen = '0;
      out_seen = '0;
      rand_nibble = 4'h0;
      for (int k = 0; k < 40; k++) begin
         @(posedge Clk); #1;
         if (ack !== 4'b0000) begin
            edges    = k + 1;
            ack_seen = ack;
            out_seen = rand_out;
            break;
         end
         rand_nibble = (k < nibs.size()) ? nibs[k] : fill;
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1; req = '0; limit = '0; rand_nibble = '0;
      repeat (2) @(posedge Clk);
      #1;
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
      n_checks++; if (rand_out !== 16'h0) begin n_fail++; $display("FAIL reset_out got=%h exp=0000", rand_out); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      Reset = 1'b0;
   endtask

   task automatic test_basic();
      logic [3:0] q[$]; int e; logic [3:0] a; logic [15:0] o;
      q = '{4'h1, 4'h2, 4'h3, 4'h4};
      limit[0 +: 16] = 16'd0;
      req = 4'b0001;
      run_txn(q, 4'h0, e, a, o);
      req = '0;
      n_checks++; if (e !== 6) begin n_fail++; $display("FAIL basic_latency got=%0d exp=6", e); end
      n_checks++; if (a !== 4'b0001) begin n_fail++; $display("FAIL basic_ack got=%b exp=0001", a); end
      n_checks++; if (o !== 16'h4321) begin n_fail++; $display("FAIL basic_out got=%h exp=4321", o); end
      @(posedge Clk); #1;
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL basic_ack_width got=%b exp=0000", ack); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
      n_checks++; if (rand_out !== 16'h4321) begin n_fail++; $display("FAIL basic_out_hold got=%h exp=4321", rand_out); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_ack [5];
      logic [3:0] got_ack [5];
      int         got_cyc [5];
      int         n;
      exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      limit = '0; rand_nibble = 4'h0; n = 0;
      req = 4'b1111;
      for (int k = 0; k < 60 && n < 5; k++) begin
         @(posedge Clk); #1;
         if (ack !== 4'b0000) begin got_ack[n] = ack; got_cyc[n] = cyc; n++; end
      end
      req = '0;
      n_checks++; if (n !== 5) begin n_fail++; $display("FAIL rr_count got=%0d exp=5", n); end
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (got_ack[i] !== exp_ack[i]) begin
            n_fail++; $display("FAIL rr_ack%0d got=%b exp=%b", i, got_ack[i], exp_ack[i]);
         end
         if (i > 0) begin
            n_checks++;
            if (got_cyc[i] - got_cyc[i-1] !== 7) begin
               n_fail++; $display("FAIL rr_spacing%0d got=%0d exp=7", i, got_cyc[i] - got_cyc[i-1]);
            end
         end
      end
      @(posedge Clk); #1;
   endtask

   task automatic test_reject_once();
      logic [3:0] q[$]; int e; logic [3:0] a; logic [15:0] o;
      q = '{4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 4'h0, 4'h0};
      do_reset();
      limit = '0; limit[16 +: 16] = 16'd10;
      req = 4'b0010;
      run_txn(q, 4'h0, e, a, o);
      req = '0;
      n_checks++; if (e !== 11) begin n_fail++; $display("FAIL rej_latency got=%0d exp=11", e); end
      n_checks++; if (a !== 4'b0010) begin n_fail++; $display("FAIL rej_ack got=%b exp=0010", a); end
      n_checks++; if (o !== 16'd7) begin n_fail++; $display("FAIL rej_out got=%h exp=0007", o); end
      @(posedge Clk); #1;
   endtask

   task automatic test_fallback();
      logic [3:0] q[$]; int e; logic [3:0] a; logic [15:0] o;
      q = {};
      limit = '0; limit[48 +: 16] = 16'd10;
      req = 4'b1000;
      run_txn(q, 4'hF, e, a, o);
      req = '0;
      n_checks++; if (e !== 21) begin n_fail++; $display("FAIL fb_latency got=%0d exp=21", e); end
      n_checks++; if (a !== 4'b1000) begin n_fail++; $display("FAIL fb_ack got=%b exp=1000", a); end
      n_checks++; if (o !== 16'd5) begin n_fail++; $display("FAIL fb_out got=%h exp=0005", o); end
      @(posedge Clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fb_busy_after got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid();
      logic [3:0] q[$]; int e; logic [3:0] a; logic [15:0] o;
      q = '{4'h9, 4'h8, 4'h7, 4'h6};
      limit = '0;
      req = 4'b0100;
      rand_nibble = 4'hA;
      @(posedge Clk); #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_pre got=%b exp=1", busy); end
      repeat (2) begin @(posedge Clk); #1; end
      Reset = 1'b1;
      @(posedge Clk); #1;
      n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_ack got=%b exp=0000", ack); end
      n_checks++; if (rand_out !== 16'h0) begin n_fail++; $display("FAIL rst_mid_out got=%h exp=0000", rand_out); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
      @(posedge Clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_hold_busy got=%b exp=0", busy); end
      Reset = 1'b0;
      run_txn(q, 4'h0, e, a, o);
      req = '0;
      n_checks++; if (e !== 6) begin n_fail++; $display("FAIL rst_regrant_latency got=%0d exp=6", e); end
      n_checks++; if (a !== 4'b0100) begin n_fail++; $display("FAIL rst_regrant_ack got=%b exp=0100", a); end
      n_checks++; if (o !== 16'h6789) begin n_fail++; $display("FAIL rst_regrant_out got=%h exp=6789", o); end
      @(posedge Clk); #1;
   endtask

   task automatic test_limit_edges();
      logic [3:0] q[$]; int e; logic [3:0] a; logic [15:0] o;
      q = {};
      for (int i = 0; i < 8; i++) q.push_back(4'($urandom));
      limit = '0; limit[0 +: 16] = 16'd1;
      req = 4'b0001;
      run_txn(q, 4'h5, e, a, o);
      req = '0;
      n_checks++; if (e !== 6) begin n_fail++; $display("FAIL lim1_latency got=%0d exp=6", e); end
      n_checks++; if (o !== 16'h0) begin n_fail++; $display("FAIL lim1_out got=%h exp=0000", o); end
      @(posedge Clk); #1;
      q = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h4, 4'h3, 4'h2, 4'h1};
      limit = '0; limit[32 +: 16] = 16'hFFFF;
      req = 4'b0100;
      run_txn(q, 4'h0, e, a, o);
      req = '0;
      n_checks++; if (e !== 11) begin n_fail++; $display("FAIL limmax_latency got=%0d exp=11", e); end
      n_checks++; if (a !== 4'b0100) begin n_fail++; $display("FAIL limmax_ack got=%b exp=0100", a); end
      n_checks++; if (o !== 16'h1234) begin n_fail++; $display("FAIL limmax_out got=%h exp=1234", o); end
      @(posedge Clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_reject_once();
      test_fallback();
      test_reset_mid();
      test_limit_edges();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
